ascii_push_arbiter: RTL and testbench
=====================================

# ascii_push_arbiter

N-channel byte-stream arbiter between the ASCII report generators (ultrasonic, temperature/humidity and future sensors) and the UART TX FIFO push port. It supersedes the two-input priority mux on the UART push path, which loses bytes when two reporters push in the same cycle. Each channel has its own buffer. Arbitration is per message, so reports never interleave on the serial line. Overflow is detected, truncated cleanly and flagged.

## Interface
- N_CH, 4: number of input channels (2..8)
- DEPTH, 16: per-channel FIFO depth in bytes, power of 2 (4..64)
- DATA_W, 8: byte width
- TERM, 8'h0A: message terminator byte
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-low
- i_push  input  N_CH  per-channel byte strobe; bit k qualifies slice k of i_push_data
- i_push_data  input  N_CH*DATA_W  channel k at [k*DATA_W +: DATA_W]
- i_full  input  1  downstream UART TX FIFO full
- i_ovf_clr  input  1  clears all o_ovf bits
- o_push  output  1  byte strobe to UART TX FIFO
- o_push_data  output  DATA_W  byte to UART TX FIFO; 0 when o_push=0
- o_ovf  output  N_CH  sticky per-channel overflow flag
- o_busy  output  1  high while a message is being forwarded

## Operation
- Per channel: circular FIFO (DEPTH entries), wr/rd pointers, entry count, msg_cnt (complete messages held, width clog2(DEPTH+1)), partial flag (last written byte was non-TERM), drop flag.
- Write, drop=0, FIFO not full: store byte and advance wr. If byte==TERM: msg_cnt+1 and clear partial; otherwise set partial.
- Write to a full FIFO: discard the byte, set o_ovf[k] and drop. If the discarded byte is TERM, handle it under the drop rules below in the same cycle.
- drop=1: discard all non-TERM bytes, even if space has freed. On TERM, clear drop and then:
  - space available: write TERM.
  - FIFO full and partial=1: overwrite the entry at wr-1 with TERM (truncated message), msg_cnt+1, clear partial.
  - FIFO full and partial=0: discard TERM.
- Arbiter FSM: IDLE, SEND.
  - IDLE: candidates are channels with msg_cnt>0. If any exist, register grant g and go to SEND.
  - SEND: o_push = ~i_full, o_push_data = head[g]. On each o_push, pop head[g]. If the popped byte == TERM: msg_cnt[g]-1, last<=g, go to IDLE.
- Only complete messages are granted, so SEND never starves mid-message.
- Same channel, same cycle: push and pop both take effect (count unchanged). msg_cnt increment and decrement in the same cycle net to zero.
- o_busy = (state==SEND).
- o_ovf: i_ovf_clr has priority over a new set in the same cycle.

## Timing
- Reset (rst=0 at a clk edge): all FIFOs empty, pointers 0, msg_cnt 0, partial 0, drop 0, o_ovf 0, state IDLE, last=N_CH-1, o_push 0, o_push_data 0, o_busy 0.
- Reset asserted mid-message: in-flight and buffered data are discarded. No further o_push is issued after the reset edge.
- o_push is combinational from the registered state, head data and i_full. The downstream FIFO must sample o_push on the same clk edge.
- Latency: terminator written at edge t → grant at edge t+1 → first o_push in the cycle after edge t+1. Best case, a message is ready 2 cycles after its TERM.
- Throughput: 1 byte/cycle while i_full=0. One IDLE cycle between consecutive messages.
- i_full=1 in SEND: o_push=0 and the head is held. Each low cycle of i_full forwards exactly one byte.

## Configuration
- ASCII_ARB_RR_EN defined: round-robin arbitration. The search starts at last+1 (mod N_CH) and takes the first candidate.
- ASCII_ARB_RR_EN undefined: fixed priority, lowest index wins (ch0 highest; legacy sr04-over-dht11 order). The last register is unused.

## Test plan
- Single message: ch1 pushes "12\n" (0x31,0x32,0x0A) on consecutive cycles, i_full=0 → o_push 3 consecutive cycles starting 2 cycles after the 0x0A write; data 0x31,0x32,0x0A; o_busy high for exactly those 3 cycles.
- Collision: ch0 "A\n" and ch2 "B\n" pushed in the same cycles → both messages are delivered unbroken, "A\n" then "B\n", and no byte is lost. RR: a repeated collision gives ch2 first next time. Fixed: ch0 is always first.
- Backpressure: i_full=1 for 5 cycles mid-message → o_push=0 during those cycles; the remaining bytes resume in order; total byte count is unchanged.
- Overflow, DEPTH=4, i_full=1: ch0 pushes "abcdef\n" → FIFO holds a,b,c,0x0A; o_ovf[0]=1. After i_full drops, "abc\n" is delivered. i_ovf_clr clears o_ovf[0] the next cycle.
- Full FIFO of complete messages (partial=0): a new "x\n" arriving on a full FIFO is discarded entirely, o_ovf set, and the earlier messages are intact.
- Reset mid-SEND: rst=0 for 1 cycle during a message → o_push=0 from the next cycle, all msg_cnt=0, no output until new messages arrive.

Source files
------------

// File: rtl/ascii_push_arbiter.sv
// Per-message arbiter from N byte-stream report channels onto one UART TX push port.
// Latency: a message is granted one edge after its terminator is stored; first byte the cycle after that.
// Backpressure: i_full holds the granted head; per-channel FIFOs truncate and flag on overflow.
// Optional build macro: ASCII_ARB_RR_EN selects round-robin arbitration (default: fixed priority, ch0 first).
module ascii_push_arbiter #(
  parameter int              N_CH   = 4,
  parameter int              DEPTH  = 16,
  parameter int              DATA_W = 8,
  parameter logic [DATA_W-1:0] TERM = DATA_W'(8'h0A)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          i_push,
  input  logic [N_CH*DATA_W-1:0]   i_push_data,
  input  logic                     i_full,
  input  logic                     i_ovf_clr,
  output logic                     o_push,
  output logic [DATA_W-1:0]        o_push_data,
  output logic [N_CH-1:0]          o_ovf,
  output logic                     o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = $clog2(N_CH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [GW-1:0]     g_q, g_d;
  logic [N_CH-1:0]   ovf_q, ovf_d;
  logic [N_CH-1:0]   ovf_set;
  logic [N_CH-1:0]   has_msg;
  logic [DATA_W-1:0] head [N_CH];
  logic [DATA_W-1:0] head_sel;
  logic              pop_vld;
  logic              found;
  logic [GW-1:0]     pick;

  assign head_sel    = head[g_q];
  assign pop_vld     = (state_q == S_SEND) && !i_full;
  assign o_push      = pop_vld;
  assign o_push_data = pop_vld ? head_sel : '0;
  assign o_busy      = (state_q == S_SEND);
  assign o_ovf       = ovf_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d, waddr;
    logic [CW-1:0]     cnt_q, cnt_d, msg_q, msg_d;
    logic              partial_q, partial_d, drop_q, drop_d;
    logic              we, pop, full, is_term;
    logic [DATA_W-1:0] wdat;

    assign wdat       = i_push_data[k*DATA_W +: DATA_W];
    assign full       = (cnt_q == CW'(DEPTH));
    assign is_term    = (wdat == TERM);
    assign pop        = pop_vld && (g_q == GW'(k));
    assign head[k]    = mem_q[rd_q];
    assign has_msg[k] = (msg_q != '0);
    assign ovf_set[k] = i_push[k] && full;

    // Channel write/drop/truncate rules plus the pop from the arbiter side.
    always_comb begin
      we        = 1'b0;
      waddr     = wr_q;
      wr_d      = wr_q;
      rd_d      = rd_q;
      cnt_d     = cnt_q;
      msg_d     = msg_q;
      partial_d = partial_q;
      drop_d    = drop_q;
      if (i_push[k]) begin
        if (!full && (!drop_q || is_term)) begin
          // Normal store; a TERM arriving while dropping also lands here and ends the drop.
          we     = 1'b1;
          wr_d   = wr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          drop_d = 1'b0;
          if (is_term) begin
            msg_d     = msg_q + 1'b1;
            partial_d = 1'b0;
          end else begin
            partial_d = 1'b1;
          end
        end else if (full && is_term) begin
          // TERM on a full FIFO: close the open message over its last byte, or discard.
          drop_d = 1'b0;
          if (partial_q) begin
            we        = 1'b1;
            waddr     = wr_q - 1'b1;
            msg_d     = msg_q + 1'b1;
            partial_d = 1'b0;
          end
        end else if (full) begin
          // Non-TERM on a full FIFO starts discarding the rest of this message.
          drop_d = 1'b1;
        end
      end
      if (pop) begin
        rd_d  = rd_q + 1'b1;
        cnt_d = cnt_d - 1'b1;
        if (head[k] == TERM) msg_d = msg_d - 1'b1;
      end
    end

    // Storage array; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdat;
    end

    // Channel bookkeeping registers.
    always_ff @(posedge clk) begin
      if (!rst) begin
        wr_q      <= '0;
        rd_q      <= '0;
        cnt_q     <= '0;
        msg_q     <= '0;
        partial_q <= 1'b0;
        drop_q    <= 1'b0;
      end else begin
        wr_q      <= wr_d;
        rd_q      <= rd_d;
        cnt_q     <= cnt_d;
        msg_q     <= msg_d;
        partial_q <= partial_d;
        drop_q    <= drop_d;
      end
    end
  end

`ifdef ASCII_ARB_RR_EN
  logic [GW-1:0] last_q, last_d;
  int            idx;

  // Round-robin search starting just after the last channel served.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (int'(last_q) + 1 + i) % N_CH;
      if (!found && has_msg[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  // Remember the channel whose message just finished.
  always_comb begin
    last_d = last_q;
    if (pop_vld && (head_sel == TERM)) last_d = g_q;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!rst) last_q <= GW'(N_CH - 1);
    else      last_q <= last_d;
  end
`else
  // Fixed priority: lowest channel index with a complete message wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (has_msg[i]) begin
        found = 1'b1;
        pick  = GW'(i);
      end
    end
  end
`endif

  // Grant a channel when idle; release after its terminator leaves.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    if (state_q == S_IDLE) begin
      if (found) begin
        g_d     = pick;
        state_d = S_SEND;
      end
    end else if (pop_vld && (head_sel == TERM)) begin
      state_d = S_IDLE;
    end
  end

  // Sticky overflow flags; a clear wins over a same-cycle set.
  always_comb begin
    ovf_d = i_ovf_clr ? '0 : (ovf_q | ovf_set);
  end

  // Arbiter and flag registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ascii_push_arbiter.sv
// Directed bench for ascii_push_arbiter with DEPTH=4 so overflow cases are short.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Bytes accepted downstream are captured in a queue with their cycle stamp.
module tb_ascii_push_arbiter;
  localparam int N_CH = 4;
  localparam int DEPTH = 4;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N_CH-1:0]  i_push = '0;
  logic [N_CH*DW-1:0] i_push_data = '0;
  logic             i_full = 1'b0;
  logic             i_ovf_clr = 1'b0;
  logic             o_push;
  logic [DW-1:0]    o_push_data;
  logic [N_CH-1:0]  o_ovf;
  logic             o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] cap_q[$];
  int         cap_t[$];
  int         base;
  string      s;

  ascii_push_arbiter #(.N_CH(N_CH), .DEPTH(DEPTH), .DATA_W(DW), .TERM(8'h0A)) dut (
    .clk(clk), .rst(rst), .i_push(i_push), .i_push_data(i_push_data),
    .i_full(i_full), .i_ovf_clr(i_ovf_clr), .o_push(o_push),
    .o_push_data(o_push_data), .o_ovf(o_ovf), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Downstream sink: records every byte that will be taken at the coming rising edge.
  always @(negedge clk) begin
    cyc++;
    #2;
    if (o_push && rst) begin
      cap_q.push_back(o_push_data);
      cap_t.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cap(input string tag, input int i, input logic [7:0] exp);
    logic [7:0] v;
    v = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
    chk(tag, {24'd0, v}, {24'd0, exp});
  endtask

  function automatic logic [31:0] ch(input int k, input logic [7:0] b);
    return {24'd0, b} << (8 * k);
  endfunction

  // One cycle: drive inputs at the falling edge, settle, then return for sampling.
  task automatic cy(input logic [3:0] p = 4'd0, input logic [31:0] d = 32'd0,
                    input logic f = 1'b0, input logic c = 1'b0);
    @(negedge clk);
    i_push = p;
    i_push_data = d;
    i_full = f;
    i_ovf_clr = c;
    #1;
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (2) cy();
    chk("rst_push", {31'd0, o_push}, 32'd0);
    chk("rst_data", {24'd0, o_push_data}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_ovf", {28'd0, o_ovf}, 32'd0);
    rst = 1'b1;

    // Single message "12\n" on ch1
    cy(4'b0010, ch(1, 8'h31));
    cy(4'b0010, ch(1, 8'h32));
    cy(4'b0010, ch(1, 8'h0A));
    cy();
    chk("t1_idle_push", {31'd0, o_push}, 32'd0);
    chk("t1_idle_busy", {31'd0, o_busy}, 32'd0);
    cy();
    chk("t1_b0_push", {31'd0, o_push}, 32'd1);
    chk("t1_b0_data", {24'd0, o_push_data}, 32'h31);
    chk("t1_b0_busy", {31'd0, o_busy}, 32'd1);
    cy();
    chk("t1_b1_data", {24'd0, o_push_data}, 32'h32);
    cy();
    chk("t1_b2_data", {24'd0, o_push_data}, 32'h0A);
    chk("t1_b2_busy", {31'd0, o_busy}, 32'd1);
    cy();
    chk("t1_end_push", {31'd0, o_push}, 32'd0);
    chk("t1_end_busy", {31'd0, o_busy}, 32'd0);

    // Collision ch0 "A\n" and ch2 "B\n", twice
    for (int r = 0; r < 2; r++) begin
      cap_q.delete(); cap_t.delete();
      cy(4'b0101, ch(0, "A") | ch(2, "B"));
      cy(4'b0101, ch(0, 8'h0A) | ch(2, 8'h0A));
      repeat (10) cy();
      chk("coll_count", cap_q.size(), 32'd4);
      chk_cap("coll_b0", 0, "A");
      chk_cap("coll_b1", 1, 8'h0A);
      chk_cap("coll_b2", 2, "B");
      chk_cap("coll_b3", 3, 8'h0A);
      if (cap_t.size() == 4) chk("coll_gap", cap_t[2] - cap_t[1], 32'd2);
      else chk("coll_gap_missing", cap_t.size(), 32'd4);
    end

    // Backpressure mid-message on ch3 "wxy\n"
    cap_q.delete(); cap_t.delete();
    cy(4'b1000, ch(3, "w"));
    cy(4'b1000, ch(3, "x"));
    cy(4'b1000, ch(3, "y"));
    cy(4'b1000, ch(3, 8'h0A));
    cy();
    cy();
    chk("bp_first_data", {24'd0, o_push_data}, {24'd0, 8'("w")});
    for (int i = 0; i < 5; i++) begin
      cy(4'd0, 32'd0, 1'b1);
      chk("bp_hold_push", {31'd0, o_push}, 32'd0);
      chk("bp_hold_busy", {31'd0, o_busy}, 32'd1);
    end
    repeat (6) cy();
    chk("bp_count", cap_q.size(), 32'd4);
    chk_cap("bp_b1", 1, "x");
    chk_cap("bp_b2", 2, "y");
    chk_cap("bp_b3", 3, 8'h0A);

    // Overflow: "abcdef\n" into a 4-deep FIFO while downstream is full
    cap_q.delete(); cap_t.delete();
    s = "abcdef\n";
    for (int i = 0; i < s.len(); i++) cy(4'b0001, ch(0, s[i]), 1'b1);
    cy(4'd0, 32'd0, 1'b1);
    chk("ovf_flag", {28'd0, o_ovf}, 32'h1);
    cy(4'd0, 32'd0, 1'b1);
    chk("ovf_busy_held", {31'd0, o_busy}, 32'd1);
    chk("ovf_push_held", {31'd0, o_push}, 32'd0);
    repeat (8) cy();
    chk("ovf_count", cap_q.size(), 32'd4);
    chk_cap("ovf_b0", 0, "a");
    chk_cap("ovf_b1", 1, "b");
    chk_cap("ovf_b2", 2, "c");
    chk_cap("ovf_b3", 3, 8'h0A);
    cy(4'd0, 32'd0, 1'b0, 1'b1);
    chk("ovf_before_clr", {28'd0, o_ovf}, 32'h1);
    cy();
    chk("ovf_cleared", {28'd0, o_ovf}, 32'h0);

    // Full FIFO of complete messages: "x\n" must vanish, drop state must end
    cap_q.delete(); cap_t.delete();
    s = "a\nb\nx\n";
    for (int i = 0; i < s.len(); i++) cy(4'b0010, ch(1, s[i]), 1'b1);
    cy(4'd0, 32'd0, 1'b1);
    chk("full_ovf", {28'd0, o_ovf}, 32'h2);
    repeat (10) cy();
    chk("full_count", cap_q.size(), 32'd4);
    chk_cap("full_b0", 0, "a");
    chk_cap("full_b1", 1, 8'h0A);
    chk_cap("full_b2", 2, "b");
    chk_cap("full_b3", 3, 8'h0A);
    cy(4'b0010, ch(1, "z"));
    cy(4'b0010, ch(1, 8'h0A));
    repeat (6) cy();
    chk("full_after_count", cap_q.size(), 32'd6);
    chk_cap("full_after_z", 4, "z");
    cy(4'd0, 32'd0, 1'b0, 1'b1);
    cy();

    // Reset during SEND of ch2 "pqrs\n"
    cap_q.delete(); cap_t.delete();
    s = "pqrs\n";
    for (int i = 0; i < s.len(); i++) cy(4'b0100, ch(2, s[i]));
    cy();
    cy();
    chk("rs_first", {24'd0, o_push_data}, {24'd0, 8'("p")});
    cy();
    rst = 1'b0;
    cy();
    chk("rs_push", {31'd0, o_push}, 32'd0);
    chk("rs_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b1;
    base = cap_q.size();
    repeat (8) cy();
    chk("rs_silent", cap_q.size(), base);
    cy(4'b0001, ch(0, "k"));
    cy(4'b0001, ch(0, 8'h0A));
    repeat (6) cy();
    chk("rs_new_count", cap_q.size(), base + 2);
    chk_cap("rs_new_k", base, "k");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
